// File: rtl/neuron_pkg.sv
// rtl/neuron_pkg.sv - shared state encoding, saturation bounds and sizing check for the neuron engine
package neuron_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        FIN  = 2'd2,
        OUT  = 2'd3
    } state_t;

    // Largest positive value representable in a dw-bit signed result
    function automatic int sat_max(input int dw);
        return (1 << (dw - 1)) - 1;
    endfunction

    // Most negative value representable in a dw-bit signed result
    function automatic int sat_min(input int dw);
        return -(1 << (dw - 1));
    endfunction

    // True when the accumulator can hold n full-scale products without wrapping
    function automatic bit acc_w_ok(input int dw, input int n, input int acc_w);
        return acc_w >= (2 * dw + $clog2(n) + 1);
    endfunction

endpackage

// File: rtl/neuron_mac_engine_mac_lane.sv
// rtl/neuron_mac_engine_mac_lane.sv - one signed DWxDW product, masked and sign-extended to ACC_W
module mac_lane #(
    parameter int DW    = 8,
    parameter int ACC_W = 21
) (
    input  logic [DW-1:0]    i_a,
    input  logic [DW-1:0]    i_b,
    input  logic             i_en,
    output logic [ACC_W-1:0] o_prod
);

    logic signed [2*DW-1:0] w_prod;

    assign w_prod = $signed(i_a) * $signed(i_b);

    // Lanes pointing past the last input contribute nothing to the beat sum
    assign o_prod = i_en ? {{(ACC_W - 2*DW){w_prod[2*DW-1]}}, w_prod} : '0;

endmodule

// File: rtl/neuron_mac_engine.sv
// rtl/neuron_mac_engine.sv - self-sequencing multi-lane MAC neuron; NEURON_MAC_RELU_EN enables ReLU before saturation
module neuron_mac_engine
    import neuron_pkg::*;
#(
    parameter int N          = 10,
    parameter int DW         = 8,
    parameter int ACC_W      = 21,
    parameter int LANES      = 1,
    parameter int BIAS_SCALE = 127,
    parameter int SHIFT      = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW*N-1:0] inp,
    input  logic [DW*N-1:0] w,
    input  logic [DW-1:0]   bias,
    input  logic            hidden,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   result,
    output logic            busy
);

    localparam int BEATS = (N + LANES - 1) / LANES;
    localparam int NP    = BEATS * LANES;
    localparam int IDX_W = $clog2(NP + 1);

    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_max(DW));
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_min(DW));

    if (!acc_w_ok(DW, N, ACC_W)) begin : g_bad_acc_w
        $error("ACC_W too narrow for DW and N");
    end

    state_t                   r_state;
    logic [DW-1:0]            r_inp [N];
    logic [DW-1:0]            r_w   [N];
    logic [DW-1:0]            r_bias;
    logic                     r_hidden;
    logic signed [ACC_W-1:0]  r_acc;
    logic [IDX_W-1:0]         r_offset;
    logic [DW-1:0]            r_result;
    logic                     r_out_valid;
    logic                     r_in_ready;
    logic                     r_busy;

    logic [DW-1:0]            w_a_pad   [NP];
    logic [DW-1:0]            w_b_pad   [NP];
    logic [IDX_W-1:0]         w_idx     [LANES];
    logic [ACC_W-1:0]         w_lane_prod [LANES];
    logic signed [ACC_W-1:0]  w_beat_sum;
    logic signed [ACC_W-1:0]  w_bias_ext;
    logic signed [ACC_W-1:0]  w_scale;
    logic signed [ACC_W-1:0]  w_bias_term;
    logic signed [ACC_W-1:0]  w_sum;
    logic signed [ACC_W-1:0]  w_scaled;
    logic signed [ACC_W-1:0]  w_act;
    logic [DW-1:0]            w_res;
    logic [IDX_W-1:0]         w_next_offset;

    // Pad the operand arrays to a whole number of beats so lane reads never go out of range
    for (genvar j = 0; j < NP; j++) begin : g_pad
        if (j < N) begin : g_real
            assign w_a_pad[j] = r_inp[j];
            assign w_b_pad[j] = r_w[j];
        end else begin : g_zero
            assign w_a_pad[j] = '0;
            assign w_b_pad[j] = '0;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign w_idx[k] = r_offset + IDX_W'(k);

        mac_lane #(
            .DW    (DW),
            .ACC_W (ACC_W)
        ) u_lane (
            .i_a    (w_a_pad[w_idx[k]]),
            .i_b    (w_b_pad[w_idx[k]]),
            .i_en   (w_idx[k] < IDX_W'(N)),
            .o_prod (w_lane_prod[k])
        );
    end

    // Sum the lane products of the current beat
    always_comb begin
        w_beat_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            w_beat_sum = w_beat_sum + $signed(w_lane_prod[k]);
        end
    end

    assign w_next_offset = r_offset + IDX_W'(LANES);
    assign w_bias_ext    = ACC_W'($signed(r_bias));
    assign w_scale       = ACC_W'(BIAS_SCALE);
    assign w_bias_term   = w_bias_ext * w_scale;
    assign w_sum         = r_acc + w_bias_term;
    assign w_scaled      = r_hidden ? (w_sum >>> SHIFT) : w_sum;

    // Activation: optional ReLU, then clamp to the signed DW-bit range
    always_comb begin
        w_act = w_scaled;
`ifdef NEURON_MAC_RELU_EN
        if (w_act < 0) begin
            w_act = '0;
        end
`endif
        if (w_act > SAT_HI) begin
            w_res = SAT_HI[DW-1:0];
        end else if (w_act < SAT_LO) begin
            w_res = SAT_LO[DW-1:0];
        end else begin
            w_res = w_act[DW-1:0];
        end
    end

    // Sequencer: capture, accumulate LANES products per beat, finish, hold result until taken
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_offset    <= '0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_bias      <= '0;
            r_hidden    <= 1'b0;
            for (int j = 0; j < N; j++) begin
                r_inp[j] <= '0;
                r_w[j]   <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        for (int j = 0; j < N; j++) begin
                            r_inp[j] <= inp[DW*j +: DW];
                            r_w[j]   <= w[DW*j +: DW];
                        end
                        r_bias     <= bias;
                        r_hidden   <= hidden;
                        r_acc      <= '0;
                        r_offset   <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= MAC;
                    end
                end
                MAC: begin
                    r_acc    <= r_acc + w_beat_sum;
                    r_offset <= w_next_offset;
                    if (w_next_offset >= IDX_W'(N)) begin
                        r_state <= FIN;
                    end
                end
                FIN: begin
                    r_result    <= w_res;
                    r_out_valid <= 1'b1;
                    r_state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign busy      = r_busy;

endmodule

// File: doc/neuron_mac_engine.md
# neuron_mac_engine

Parametrised, self-sequencing neuron engine: accepts one input vector, weight vector and bias per transaction, multiply-accumulates LANES products per cycle under an internal FSM, then adds scaled bias, applies the optional hidden-layer shift, and activates/saturates to a DW-bit result. It is the next generation of the per-neuron datapath. Offset sequencing moves inside the block, and the block adds valid/ready handshakes, multi-lane MAC, signed saturation and a compile-time ReLU. It sits between the layer controller (input side) and the layer output buffer (result side).

## Interface
- N, 10: inputs per neuron.
- DW, 8: operand/result width, signed two's complement.
- ACC_W, 21: accumulator width; must be ≥ 2*DW + $clog2(N) + 1.
- LANES, 1: products summed per MAC cycle; 1 ≤ LANES ≤ N.
- BIAS_SCALE, 127: signed constant multiplied into bias.
- SHIFT, 9: arithmetic right shift applied when hidden=1.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  transaction offered.
- in_ready  out  1  engine idle, accepts transaction.
- inp  in  DW*N  input vector, element i at [DW*i +: DW].
- w  in  DW*N  weight vector, same packing.
- bias  in  DW  signed bias.
- hidden  in  1  hidden-layer scaling select.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  DW  activated, saturated neuron output.
- busy  out  1  high in any state except IDLE.

## Operation
- FSM states: IDLE, MAC, FIN, OUT.
- IDLE: in_ready=1. On in_valid, capture inp, w, bias, hidden into registers; clear acc; offset=0; go to MAC.
- MAC: acc += Σ sext(inp[k]*w[k]) for k = offset … offset+LANES-1.
  - Indices ≥ N contribute 0.
  - offset += LANES each cycle.
  - After B = ceil(N/LANES) beats, go to FIN.
- FIN: sum = acc + sext(bias*BIAS_SCALE). If hidden, sum = sum >>> SHIFT. Apply activation, register result, go to OUT.
- Activation: clamp to [-2^(DW-1), 2^(DW-1)-1]; with ReLU enabled, negatives become 0 first.
- OUT: out_valid=1; result held stable. On out_ready, go to IDLE.
- Arithmetic: products are 2*DW signed. acc and sum are ACC_W signed and wrap modulo 2^ACC_W (ACC_W sizing guarantees no wrap for legal parameters).
- in_valid outside IDLE is ignored (in_ready=0). out_ready outside OUT is ignored.
- Captured operands are unaffected by input changes after acceptance.

## Timing
- Reset (rst=0 at an edge): state IDLE; in_ready=1; out_valid=0; busy=0; result=0; acc=0; offset=0. Mid-transaction reset discards the transaction.
- Accept at edge A. MAC occupies edges A+1 … A+B, FIN is edge A+B+1, and out_valid is high from edge A+B+1.
- Latency: N=10, LANES=1 gives 11 cycles; LANES=4 gives 4 cycles.
- Result handshake completes at the edge where out_valid & out_ready. in_ready rises the same edge. The next accept is at the earliest following edge, so no accept/complete overlap.
- Backpressure: out_valid and result remain stable until accepted.

## Configuration
- NEURON_MAC_RELU_EN defined: ReLU precedes saturation; result range 0 … 2^(DW-1)-1.
- NEURON_MAC_RELU_EN undefined: pure signed saturation; negative results pass through.

## Structure
- Package neuron_pkg:
  - state enum (IDLE, MAC, FIN, OUT);
  - saturation bound constants as functions of DW;
  - ACC_W sizing check function.
- Sub-module mac_lane: one signed DW×DW multiply with index-valid masking and sign extension to ACC_W. Instantiated LANES times via generate; the adder tree stays in the top level.

## Test plan
- N=10, LANES=1; inp all 1, w all 2, bias 0, hidden 0 -> result 20; out_valid 11 cycles after accept.
- inp all 1, w all -3, bias 0 -> with RELU_EN result 0; without, result -30 (8'hE2).
- inp all 127, w all 127, bias 0 -> sum 161290 -> result 127 (positive saturation).
- inp all 64, w all 64, hidden 1, bias 0 -> 40960>>>9 = 80 -> result 80.
- LANES=4, N=10, random vectors -> result matches LANES=1 model; out_valid 4 cycles after accept; indices 10, 11 masked.
- out_ready held low 5 cycles -> result, out_valid stable, in_ready 0. Then rst=0 mid-MAC on the next transaction -> next cycle IDLE, in_ready=1, out_valid=0, result=0.
